br_table_decoder: RTL and testbench
===================================

BR_TABLE_DECODER -- requirements
Module: br_table_decoder

Interface
REQ-001 SHALL have parameter LABEL_W, default 32, width of decoded label (1..32).
REQ-002 SHALL have parameter MAX_LEB, default 5, max bytes per LEB128 field.
REQ-003 SHALL have parameter LEN_W, default 16, width of consumed-byte counter.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  begin decode; sampled only in IDLE.
REQ-007 SHALL have port index  input  32  br_table operand, latched on accepted start.
REQ-008 SHALL have port byte_in  input  8  immediate stream byte following the br_table opcode.
REQ-009 SHALL have port byte_valid  input  1  byte_in valid.
REQ-010 SHALL have port byte_ready  output  1  decoder accepts byte; a transfer occurs when byte_valid and byte_ready are both high.
REQ-011 SHALL have port done  output  1  one-cycle pulse; label and length valid.
REQ-012 SHALL have port label  output  LABEL_W  selected branch depth.
REQ-013 SHALL have port length  output  LEN_W  total immediate bytes consumed.
REQ-014 SHALL have port error  output  1  malformed immediate, level, held until next start.
REQ-015 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-016 SHALL implement states IDLE, COUNT, ENTRY, DEFAULT, DONE, ERROR.
REQ-017 IDLE: byte_ready=0; start=1 latches index, clears length/error, enters COUNT next cycle.
REQ-018 COUNT/ENTRY/DEFAULT: byte_ready=1; each transfer adds 7-bit group (byte_in[6:0]) at shift 7*k and increments length.
REQ-019 Field ends on a transfer with byte_in[7]=0; no state change on cycles without a transfer.
REQ-020 COUNT end: N = decoded value; N=0 goes directly to DEFAULT, else ENTRY with entry counter 0.
REQ-021 ENTRY end: if entry counter == latched index, capture value into label; increment counter; counter == N goes to DEFAULT.
REQ-022 DEFAULT end: if latched index >= N, capture value into label; go to DONE.
REQ-023 All N entries and the default SHALL always be consumed so length is exact, regardless of index.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; label/length hold until next start.
REQ-025 A field with byte_in[7]=1 on byte MAX_LEB SHALL go to ERROR.
REQ-026 COUNT values above 2^32-1, or label values above 2^LABEL_W-1, SHALL go to ERROR.
REQ-027 length overflow past 2^LEN_W-1 SHALL go to ERROR.
REQ-028 ERROR: error=1, byte_ready=0, done never pulses, returns to IDLE next cycle; error holds until next start.
REQ-029 Latency from last transfer to done SHALL be exactly 1 cycle.
REQ-030 A start asserted while busy SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force IDLE, label=0, length=0, done=0, error=0, busy=0, byte_ready=0.
REQ-032 reset mid-decode SHALL discard partial state; the first decode after release SHALL behave as from power-up.

Structure
REQ-033 State encoding and the br_table opcode constant SHALL live in the shared cpu.vh package.
REQ-034 A sub-module leb128_u32_acc (accumulator, shift counter, overflow/too-long flags) SHALL be instantiated once and cleared between fields.

Verification
REQ-035 Bytes 02 00 01 02, index=1 -> done, label=1, length=4, error=0.
REQ-036 Bytes 02 00 01 02, index=5 -> label=2 (default), length=4.
REQ-037 Bytes 01 80 01 03, index=0 -> label=128, length=4; with byte_valid low on alternate cycles -> same result.
REQ-038 Bytes 00 07, index=0 -> label=7, length=2.
REQ-039 Bytes 01 80 80 80 80 80 00 -> error=1 after 5th byte of entry, no done.
REQ-040 reset low after second byte of 02 00 01 02, then full stream with index=0 -> label=0, length=4.

Source files
------------

// File: rtl/br_table_decoder_pkg.sv
// Shared definitions for the br_table immediate decoder: FSM state encoding,
// the br_table opcode value and a state-class helper.
package br_table_decoder_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COUNT   = 3'd1,
      S_ENTRY   = 3'd2,
      S_DEFAULT = 3'd3,
      S_DONE    = 3'd4,
      S_ERROR   = 3'd5
   } state_t;

   localparam logic [7:0] BR_TABLE_OPCODE = 8'h0E;

   // States in which the decoder consumes LEB128 bytes from the stream.
   function automatic logic takes_bytes(input state_t s);
      return (s == S_COUNT) || (s == S_ENTRY) || (s == S_DEFAULT);
   endfunction

endpackage

// File: rtl/leb128_u32_acc.sv
// Unsigned LEB128 accumulator for one u32 field. The value output already
// includes the group on byte_in, so the owner can use it on the terminating
// transfer. overflow/too_long describe the byte currently presented.
module leb128_u32_acc #(
   parameter int unsigned MAX_LEB = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] value,
   output logic        last,
   output logic        overflow,
   output logic        too_long
);

   localparam int unsigned CNT_W = $clog2(MAX_LEB + 1);

   logic [31:0]      acc_q;
   logic [CNT_W-1:0] grp_q;
   logic [63:0]      wide;
   int unsigned      shamt;

   // Merge the incoming 7-bit group at its shift; bits landing above 31 mean overflow.
   always_comb begin
      shamt    = 7 * 32'(grp_q);
      wide     = {32'd0, acc_q} | ({57'd0, byte_in[6:0]} << shamt);
      value    = wide[31:0];
      overflow = |wide[63:32];
      last     = ~byte_in[7];
      too_long = byte_in[7] && (grp_q == CNT_W'(MAX_LEB - 1));
   end

   // Accumulator and group counter; clear wins over a shift in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q <= '0;
         grp_q <= '0;
      end else if (clear) begin
         acc_q <= '0;
         grp_q <= '0;
      end else if (shift_en) begin
         acc_q <= value;
         grp_q <= grp_q + 1'b1;
      end
   end

endmodule

// File: rtl/br_table_decoder.sv
// Decodes the br_table immediate (count, N label entries, default label)
// from a byte stream and selects the branch depth for a given index. Every
// field is consumed so the reported length covers the whole immediate.
module br_table_decoder
   import br_table_decoder_pkg::*;
#(
   parameter int unsigned LABEL_W = 32,
   parameter int unsigned MAX_LEB = 5,
   parameter int unsigned LEN_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        index,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               done,
   output logic [LABEL_W-1:0] label,
   output logic [LEN_W-1:0]   length,
   output logic               error,
   output logic               busy
);

   state_t             state_q, state_d;
   logic [31:0]        idx_q, idx_d;
   logic [31:0]        n_q, n_d;
   logic [31:0]        ent_q, ent_d;
   logic [LABEL_W-1:0] label_q, label_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               err_q, err_d;

   logic               xfer;
   logic               acc_clear;
   logic [31:0]        acc_value;
   logic               acc_last, acc_ovf, acc_long;
   logic [63:0]        label_hi;
   logic               label_ovf;

   leb128_u32_acc #(.MAX_LEB(MAX_LEB)) u_acc (
      .clk      (clk),
      .reset    (reset),
      .clear    (acc_clear),
      .shift_en (xfer),
      .byte_in  (byte_in),
      .value    (acc_value),
      .last     (acc_last),
      .overflow (acc_ovf),
      .too_long (acc_long)
   );

   // Output decode straight from registered state.
   always_comb begin
      byte_ready = takes_bytes(state_q);
      done       = (state_q == S_DONE);
      busy       = (state_q != S_IDLE);
      error      = err_q;
      label      = label_q;
      length     = len_q;
      xfer       = byte_ready && byte_valid;
      label_hi   = {32'd0, acc_value} >> LABEL_W;
      label_ovf  = |label_hi;
   end

   // Next-state and datapath updates; the three byte states share the field handling.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      n_d       = n_q;
      ent_d     = ent_q;
      label_d   = label_q;
      len_d     = len_q;
      err_d     = err_q;
      acc_clear = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d     = index;
               len_d     = '0;
               err_d     = 1'b0;
               acc_clear = 1'b1;
               state_d   = S_COUNT;
            end
         end
         S_COUNT, S_ENTRY, S_DEFAULT: begin
            if (xfer) begin
               if (acc_ovf || acc_long || (&len_q) ||
                   ((state_q != S_COUNT) && label_ovf)) begin
                  err_d     = 1'b1;
                  acc_clear = 1'b1;
                  state_d   = S_ERROR;
               end else begin
                  len_d = len_q + 1'b1;
                  if (acc_last) begin
                     acc_clear = 1'b1;
                     if (state_q == S_COUNT) begin
                        n_d     = acc_value;
                        ent_d   = '0;
                        state_d = (acc_value == 32'd0) ? S_DEFAULT : S_ENTRY;
                     end else if (state_q == S_ENTRY) begin
                        if (ent_q == idx_q) label_d = acc_value[LABEL_W-1:0];
                        ent_d = ent_q + 32'd1;
                        if ((ent_q + 32'd1) == n_q) state_d = S_DEFAULT;
                     end else begin
                        if (idx_q >= n_q) label_d = acc_value[LABEL_W-1:0];
                        state_d = S_DONE;
                     end
                  end
               end
            end
         end
         S_DONE, S_ERROR: state_d = S_IDLE;
         default:         state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         n_q     <= '0;
         ent_q   <= '0;
         label_q <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         n_q     <= n_d;
         ent_q   <= ent_d;
         label_q <= label_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_br_table_decoder.sv
// Scoreboard bench for br_table_decoder: stimulus pushes expected results,
// a negedge monitor pops and compares whenever done or the error state shows.
module tb_br_table_decoder;

   logic        clk, reset, start, byte_valid, byte_ready, done, error, busy;
   logic [31:0] index, label;
   logic [7:0]  byte_in;
   logic [15:0] length;

   typedef struct {
      logic [31:0] label;
      logic [15:0] length;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   int unsigned n_cmp = 0;
   int unsigned n_fail = 0;
   logic [7:0]  stim[8];
   int          stim_n;

   br_table_decoder #(.LABEL_W(32), .MAX_LEB(5), .LEN_W(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .index      (index),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .done       (done),
      .label      (label),
      .length     (length),
      .error      (error),
      .busy       (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: one scoreboard entry per done pulse or error-state cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && (done || (busy && error))) begin
         if (sb.size() == 0) begin
            check("unexpected_output", {done, error}, 64'd0);
         end else begin
            e = sb.pop_front();
            if (e.err) begin
               check("error_without_done", {62'd0, done, error}, 64'd1);
            end else begin
               check("label", label, e.label);
               check("length", length, e.length);
               check("error_at_done", error, 64'd0);
            end
         end
      end
   end

   task automatic load(input int n, input logic [63:0] p);
      stim_n = n;
      for (int i = 0; i < n; i++) stim[i] = p[8*(n-1-i) +: 8];
   endtask

   task automatic start_decode(input logic [31:0] idx);
      start = 1'b1;
      index = idx;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input bit gap, input bit stray, input bit expect_err);
      int unsigned i = 0;
      int unsigned guard = 0;
      while (i < stim_n && guard < 100) begin
         if (!busy) break;
         byte_in    = stim[i];
         byte_valid = 1'b1;
         if (stray && i == 0) begin
            start = 1'b1;
            index = 32'd0;
         end
         if (byte_ready) begin
            @(posedge clk); #1;
            i++;
            start = 1'b0;
            if (gap) begin
               byte_valid = 1'b0;
               @(posedge clk); #1;
            end
         end else begin
            @(posedge clk); #1;
         end
         guard++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (!expect_err) check("all_bytes_taken", i, stim_n);
   endtask

   task automatic wait_idle();
      int unsigned g = 0;
      while (busy && g < 40) begin
         @(posedge clk); #1;
         g++;
      end
      check("return_idle", busy, 64'd0);
   endtask

   task automatic run(input logic [31:0] idx, input int n, input logic [63:0] p,
                      input bit gap, input bit stray,
                      input logic [31:0] exp_label, input logic [15:0] exp_len, input bit exp_err);
      exp_t e;
      e.label  = exp_label;
      e.length = exp_len;
      e.err    = exp_err;
      sb.push_back(e);
      load(n, p);
      start_decode(idx);
      feed(gap, stray, exp_err);
      wait_idle();
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; index = '0; byte_in = '0; byte_valid = 1'b0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_ready", byte_ready, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_label", label, 0);
      check("rst_length", length, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      run(32'd1, 4, 64'h02000102, 1'b0, 1'b0, 32'd1, 16'd4, 1'b0);
      @(posedge clk); #1;
      check("label_hold", label, 32'd1);
      check("length_hold", length, 16'd4);

      run(32'd5, 4, 64'h02000102, 1'b0, 1'b0, 32'd2, 16'd4, 1'b0);
      run(32'd0, 4, 64'h01800103, 1'b0, 1'b0, 32'd128, 16'd4, 1'b0);
      run(32'd0, 4, 64'h01800103, 1'b1, 1'b0, 32'd128, 16'd4, 1'b0);
      run(32'd0, 2, 64'h0007, 1'b0, 1'b0, 32'd7, 16'd2, 1'b0);

      // Entry label with continuation on the 5th byte.
      run(32'd0, 7, 64'h01808080808000, 1'b0, 1'b0, 32'd0, 16'd0, 1'b1);
      check("error_held", error, 1);
      @(posedge clk); #1;
      check("error_still_held", error, 1);

      // Count value exceeding 32 bits.
      run(32'd0, 5, 64'h8080808010, 1'b0, 1'b0, 32'd0, 16'd0, 1'b1);

      // Maximum 5-byte label in the default slot.
      run(32'd3, 6, 64'h00FFFFFFFF0F, 1'b0, 1'b0, 32'hFFFF_FFFF, 16'd6, 1'b0);

      // Start while busy (index 0) must not disturb the latched index 1.
      run(32'd1, 4, 64'h02050607, 1'b0, 1'b1, 32'd6, 16'd4, 1'b0);
      // Index equal to N selects the default.
      run(32'd2, 4, 64'h02050607, 1'b0, 1'b0, 32'd7, 16'd4, 1'b0);

      // Reset in the middle of a decode.
      load(2, 64'h0200);
      start_decode(32'd2);
      feed(1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_ready", byte_ready, 0);
      check("midrst_done", done, 0);
      check("midrst_error", error, 0);
      check("midrst_label", label, 0);
      check("midrst_length", length, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      run(32'd0, 4, 64'h02000102, 1'b0, 1'b0, 32'd0, 16'd4, 1'b0);

      repeat (3) @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
